// File: rtl/ex_hazard_ctrl.sv
// EX-stage hazard control: operand forwarding, load-use interlock,
// and multi-cycle op sequencing with timeout and redirect abort.
module ex_hazard_ctrl #(
    parameter int MC_TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       dec_valid,
    input  logic [4:0] dec_rs1,
    input  logic [4:0] dec_rs2,
    input  logic [4:0] dec_rd,
    input  logic       dec_is_load,
    input  logic       dec_is_mc,
    input  logic       mc_done,
    input  logic       redirect,
    output logic       stall,
    output logic       flush_ex,
    output logic [1:0] fwd_src1,
    output logic [1:0] fwd_src2,
    output logic       mc_start,
    output logic       mc_abort,
    output logic       mc_timeout
);

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       is_load;
    } slot_t;

    typedef enum logic {RUN, MC_BUSY} state_t;

    localparam logic [7:0] LAST = 8'(MC_TIMEOUT - 1);

    state_t     state;
    slot_t      ex_q;
    slot_t      mem_q;
    logic [7:0] cnt;
    logic       to_q;

    logic       busy;
    logic       load_use;
    logic       stall_c;
    logic       flush_c;
    logic       issue;
    logic       start_c;
    logic       tmo_hit;
    logic       abort_c;

    function automatic logic hit(slot_t s, logic [4:0] rs);
        return s.valid && (s.rd != 5'd0) && (s.rd == rs);
    endfunction

    function automatic logic [1:0] src(slot_t ex, slot_t mem,
                                       logic [4:0] rs);
        logic [1:0] r;
        r = 2'd0;
        if (hit(ex, rs) && !ex.is_load)
            r = 2'd1;
        else if (hit(mem, rs))
            r = 2'd2;
        return r;
    endfunction

    assign busy     = (state == MC_BUSY);
    assign load_use = !busy && !redirect && dec_valid && ex_q.is_load
                      && (hit(ex_q, dec_rs1) || hit(ex_q, dec_rs2));
    assign stall_c  = !redirect && (busy || load_use);
    assign flush_c  = redirect || load_use;
    assign issue    = dec_valid && !stall_c && !redirect;
    assign start_c  = issue && dec_is_mc;
    assign tmo_hit  = busy && !redirect && !mc_done && (cnt == LAST);
    assign abort_c  = (busy && redirect) || tmo_hit;

    // Combinational outputs are forced low while reset is held.
    assign stall      = rst && stall_c;
    assign flush_ex   = rst && flush_c;
    assign mc_start   = rst && start_c;
    assign mc_abort   = rst && abort_c;
    assign fwd_src1   = rst ? src(ex_q, mem_q, dec_rs1) : 2'd0;
    assign fwd_src2   = rst ? src(ex_q, mem_q, dec_rs2) : 2'd0;
    assign mc_timeout = to_q;

    // Slots freeze while a multi-cycle op holds EX.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_q  <= '0;
            mem_q <= '0;
        end else if (redirect) begin
            ex_q  <= '0;
            mem_q <= '0;
        end else if (!busy) begin
            mem_q <= ex_q;
            if (issue)
                ex_q <= '{valid: 1'b1, rd: dec_rd, is_load: dec_is_load};
            else
                ex_q <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RUN;
            cnt   <= 8'd0;
            to_q  <= 1'b0;
        end else begin
            unique case (state)
                RUN: begin
                    if (start_c) begin
                        state <= MC_BUSY;
                        cnt   <= 8'd0;
                    end
                end
                MC_BUSY: begin
                    if (redirect || mc_done || cnt == LAST)
                        state <= RUN;
                    else
                        cnt <= cnt + 8'd1;
                    if (tmo_hit)
                        to_q <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Randomized and directed bench for ex_hazard_ctrl against a
// behavioural pipeline model.
module tb_ex_hazard_ctrl;

    localparam int TO = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       dec_valid = 1'b0;
    logic [4:0] dec_rs1 = '0;
    logic [4:0] dec_rs2 = '0;
    logic [4:0] dec_rd = '0;
    logic       dec_is_load = 1'b0;
    logic       dec_is_mc = 1'b0;
    logic       mc_done = 1'b0;
    logic       redirect = 1'b0;
    logic       stall;
    logic       flush_ex;
    logic [1:0] fwd_src1;
    logic [1:0] fwd_src2;
    logic       mc_start;
    logic       mc_abort;
    logic       mc_timeout;

    always #5 clk = ~clk;

    ex_hazard_ctrl #(.MC_TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .dec_valid  (dec_valid),
        .dec_rs1    (dec_rs1),
        .dec_rs2    (dec_rs2),
        .dec_rd     (dec_rd),
        .dec_is_load(dec_is_load),
        .dec_is_mc  (dec_is_mc),
        .mc_done    (mc_done),
        .redirect   (redirect),
        .stall      (stall),
        .flush_ex   (flush_ex),
        .fwd_src1   (fwd_src1),
        .fwd_src2   (fwd_src2),
        .mc_start   (mc_start),
        .mc_abort   (mc_abort),
        .mc_timeout (mc_timeout)
    );

    int n_run  = 0;
    int n_fail = 0;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Model: two in-flight instructions plus multi-cycle bookkeeping.
    typedef struct {
        bit v;
        int rd;
        bit ld;
    } ins_t;

    ins_t m_ex;
    ins_t m_mem;
    bit   m_busy;
    int   m_elapsed;
    bit   m_to;
    bit   obs_stall;
    bit   obs_abort;

    function automatic int use_src(int rs);
        if (rs == 0) return 0;
        if (m_ex.v && m_ex.rd == rs && !m_ex.ld) return 1;
        if (m_mem.v && m_mem.rd == rs) return 2;
        return 0;
    endfunction

    task automatic model_clear();
        m_ex      = '{0, 0, 0};
        m_mem     = '{0, 0, 0};
        m_busy    = 0;
        m_elapsed = 0;
        m_to      = 0;
    endtask

    task automatic tick(bit v, int r1, int r2, int rd, bit ld,
                        bit mc, bit done, bit rdr);
        bit lu, es, ef, iss, est, tmo, eab;
        int f1, f2;
        dec_valid   = v;
        dec_rs1     = 5'(r1);
        dec_rs2     = 5'(r2);
        dec_rd      = 5'(rd);
        dec_is_load = ld;
        dec_is_mc   = mc;
        mc_done     = done;
        redirect    = rdr;
        #1;
        lu = !m_busy && !rdr && v && m_ex.v && m_ex.ld && m_ex.rd != 0
             && (m_ex.rd == r1 || m_ex.rd == r2);
        es  = !rdr && (m_busy || lu);
        ef  = rdr || lu;
        iss = v && !es && !rdr;
        est = iss && mc;
        tmo = m_busy && !rdr && !done && (m_elapsed == TO - 1);
        eab = (m_busy && rdr) || tmo;
        f1  = use_src(r1);
        f2  = use_src(r2);
        if (!rst) begin
            {es, ef, est, eab} = '0;
            f1 = 0;
            f2 = 0;
        end
        chk("stall", 32'(stall), 32'(es));
        chk("flush_ex", 32'(flush_ex), 32'(ef));
        chk("fwd_src1", 32'(fwd_src1), 32'(f1));
        chk("fwd_src2", 32'(fwd_src2), 32'(f2));
        chk("mc_start", 32'(mc_start), 32'(est));
        chk("mc_abort", 32'(mc_abort), 32'(eab));
        chk("mc_timeout", 32'(mc_timeout), 32'(rst ? m_to : 1'b0));
        obs_stall = stall;
        obs_abort = mc_abort;
        @(posedge clk);
        if (rst) begin
            if (rdr) begin
                m_ex  = '{0, 0, 0};
                m_mem = '{0, 0, 0};
            end else if (!m_busy) begin
                m_mem = m_ex;
                m_ex  = iss ? '{1, rd, ld} : '{0, 0, 0};
            end
            if (m_busy) begin
                if (rdr || done || tmo) m_busy = 0;
                else m_elapsed++;
            end else if (est) begin
                m_busy    = 1;
                m_elapsed = 0;
            end
            if (tmo) m_to = 1;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        model_clear();
        tick(1, 1, 1, 1, 1, 1, 1, 1);
        tick(1, 2, 3, 4, 0, 1, 0, 1);
        rst = 1'b1;
    endtask

    initial begin
        int stalls;
        int abort_at;
        bit ph;
        model_clear();
        @(negedge clk);
        do_reset();

        // Forward from EX then MEM.
        tick(1, 0, 0, 5, 0, 0, 0, 0);
        tick(1, 5, 0, 6, 0, 0, 0, 0);
        tick(1, 0, 5, 8, 0, 0, 0, 0);

        // Load-use interlock, then MEM forward on retry.
        tick(1, 0, 0, 7, 1, 0, 0, 0);
        tick(1, 0, 7, 9, 0, 0, 0, 0);
        tick(1, 0, 7, 9, 0, 0, 0, 0);

        // x0 never forwards or stalls.
        tick(1, 0, 0, 0, 1, 0, 0, 0);
        tick(1, 0, 0, 3, 0, 0, 0, 0);

        // Multi-cycle op completing on the 11th busy cycle.
        tick(1, 0, 0, 9, 0, 1, 0, 0);
        stalls = 0;
        for (int i = 0; i < 11; i++) begin
            tick(1, 9, 0, 10, 0, 0, i == 10, 0);
            stalls += int'(obs_stall);
        end
        chk("mc_stall_len", 32'(stalls), 32'd11);
        tick(1, 9, 0, 10, 0, 0, 0, 0);
        chk("mc_stall_end", 32'(obs_stall), 32'd0);

        // Multi-cycle op that never completes.
        tick(1, 0, 0, 4, 0, 1, 0, 0);
        abort_at = -1;
        for (int i = 0; i < TO + 2; i++) begin
            tick(1, 4, 1, 2, 0, 0, 0, 0);
            if (obs_abort && abort_at < 0) abort_at = i;
        end
        chk("timeout_at", 32'(abort_at), 32'(TO - 1));
        chk("timeout_sticky", 32'(mc_timeout), 32'd1);

        // Redirect coincident with mc_done during busy.
        tick(1, 0, 0, 12, 0, 1, 0, 0);
        tick(1, 12, 0, 13, 0, 0, 0, 0);
        tick(1, 12, 0, 13, 0, 0, 1, 1);
        tick(1, 12, 12, 14, 0, 0, 0, 0);

        // Reset in the middle of a busy op.
        tick(1, 0, 0, 15, 0, 1, 0, 0);
        tick(1, 0, 0, 15, 0, 0, 0, 0);
        do_reset();
        tick(1, 15, 0, 1, 0, 0, 0, 0);
        chk("post_reset_stall", 32'(obs_stall), 32'd0);

        for (int n = 0; n < 6000; n++) begin
            ph = (n / 1000) % 2 == 1;
            if ($urandom_range(0, 599) == 0) do_reset();
            tick($urandom_range(0, 3) != 0,
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)),
                 $urandom_range(0, 9) < 3,
                 $urandom_range(0, 9) == 0,
                 ph ? ($urandom_range(0, 99) == 0)
                    : ($urandom_range(0, 7) == 0),
                 ph ? ($urandom_range(0, 199) == 0)
                    : ($urandom_range(0, 19) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
